// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants.
//   fetch_state_t : fetch FSM encoding (IDLE/REQ/DROP)
//   iq_entry_t    : instruction-queue entry {pc, instr} at the default 32-bit widths
//   WORD_OFFSET_MASK : byte-offset bits cleared to word-align a PC
package cpu_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WORD_OFFSET_MASK = 3;
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } iq_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read handshake plus decode-side instruction port.
//   imem_req_o/imem_addr_o : read request and word-aligned address (fetch -> memory)
//   imem_ack_i/imem_rdata_i: data return strobe and word (memory -> fetch)
//   ir_valid_o/ir_o/ir_pc_o: queue head instruction and its PC (fetch -> decode)
//   ir_ready_i             : decode accepts the head (decode -> fetch)
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic                  imem_ack_i;
    logic [DATA_WIDTH-1:0] imem_rdata_i;
    logic                  ir_valid_o;
    logic                  ir_ready_i;
    logic [DATA_WIDTH-1:0] ir_o;
    logic [ADDR_WIDTH-1:0] ir_pc_o;
    modport master (
        output imem_req_o, imem_addr_o, ir_valid_o, ir_o, ir_pc_o,
        input  imem_ack_i, imem_rdata_i, ir_ready_i
    );
    modport slave (
        input  imem_req_o, imem_addr_o, ir_valid_o, ir_o, ir_pc_o,
        output imem_ack_i, imem_rdata_i, ir_ready_i
    );
endinterface

// File: rtl/instr_queue.sv
// instr_queue: synchronous FIFO with a flush that overrides push/pop.
//   clk, rst_n (async active-low), push, pop, flush, din
//   dout (head entry), count, empty, full
module instr_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign dout  = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues one instruction-memory read at a time for the current PC and
// queues returned words with their PC for decode; discards work on redirect.
//   clk, RESET (async active-low), pc_i, redirect_i
//   pc_advance_o : fetch completed this cycle, PC may step sequentially
//   bus          : memory handshake and decode port (fetch_unit_if.master)
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int QDEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  redirect_i,
    output logic                  pc_advance_o,
    fetch_unit_if.master          bus
);
    localparam int CW = $clog2(QDEPTH) + 1;
    fetch_state_t                     state;
    logic [CW-1:0]                    count;
    logic                             empty, full, issue, pop;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
    logic                             unused_ok;
    assign issue        = ~redirect_i & (count < CW'(QDEPTH));
    assign pc_advance_o = (state == FETCH_REQ) & bus.imem_ack_i & ~redirect_i;
    assign pop          = bus.ir_valid_o & bus.ir_ready_i;
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state           <= FETCH_IDLE;
            bus.imem_req_o  <= 1'b0;
            bus.imem_addr_o <= '0;
        end else begin
            case (state)
                FETCH_IDLE: if (issue) begin
                    bus.imem_req_o  <= 1'b1;
                    bus.imem_addr_o <= pc_i & ~ADDR_WIDTH'(WORD_OFFSET_MASK);
                    state           <= FETCH_REQ;
                end
                // An outstanding read cannot be cancelled; a redirect only marks its data as dead.
                FETCH_REQ: if (bus.imem_ack_i) begin
                    bus.imem_req_o <= 1'b0;
                    state          <= FETCH_IDLE;
                end else if (redirect_i) begin
                    state <= FETCH_DROP;
                end
                FETCH_DROP: if (bus.imem_ack_i) begin
                    bus.imem_req_o <= 1'b0;
                    state          <= FETCH_IDLE;
                end
                default: begin
                    bus.imem_req_o <= 1'b0;
                    state          <= FETCH_IDLE;
                end
            endcase
        end
    end
    instr_queue #(.W(ADDR_WIDTH + DATA_WIDTH), .DEPTH(QDEPTH), .CW(CW)) u_queue (
        .clk   (clk),
        .rst_n (RESET),
        .push  (pc_advance_o),
        .pop   (pop),
        .flush (redirect_i),
        .din   ({bus.imem_addr_o, bus.imem_rdata_i}),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );
    assign bus.ir_valid_o = ~empty;
    assign bus.ir_pc_o    = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign bus.ir_o       = head[DATA_WIDTH-1:0];
    // The issue test on count already implies not-full.
    assign unused_ok = &{1'b0, full};
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] pc_i = '0;
    logic        redirect_i = 1'b0;
    logic        pc_advance_o;
    int          total = 0;
    int          bad = 0;

    fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .QDEPTH(2)) dut (
        .clk          (clk),
        .RESET        (RESET),
        .pc_i         (pc_i),
        .redirect_i   (redirect_i),
        .pc_advance_o (pc_advance_o),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards apply to the following edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.imem_ack_i   = 1'b0;
        bus.imem_rdata_i = '0;
        bus.ir_ready_i   = 1'b0;
        #3;
        chk("rst_req", bus.imem_req_o, 0);
        chk("rst_addr", bus.imem_addr_o, 0);
        chk("rst_valid", bus.ir_valid_o, 0);
        chk("rst_ir", bus.ir_o, 0);
        chk("rst_irpc", bus.ir_pc_o, 0);
        chk("rst_adv", pc_advance_o, 0);
        #9 RESET = 1'b1;
        // first fetch at 0x0
        tick();
        chk("f0_req", bus.imem_req_o, 1);
        chk("f0_addr", bus.imem_addr_o, 32'h0);
        chk("f0_adv_pre", pc_advance_o, 0);
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h1111_1111;
        #1 chk("f0_adv", pc_advance_o, 1);
        tick();
        bus.imem_ack_i = 1'b0;
        #1;
        chk("f0_valid", bus.ir_valid_o, 1);
        chk("f0_ir", bus.ir_o, 32'h1111_1111);
        chk("f0_irpc", bus.ir_pc_o, 32'h0);
        chk("f0_req_drop", bus.imem_req_o, 0);
        // fill the queue with decode stalled
        pc_i = 32'h4;
        tick();
        chk("f1_req", bus.imem_req_o, 1);
        chk("f1_addr", bus.imem_addr_o, 32'h4);
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h2222_2222;
        tick();
        bus.imem_ack_i = 1'b0; pc_i = 32'h8;
        #1;
        chk("full_hold_ir", bus.ir_o, 32'h1111_1111);
        tick();
        chk("full_noreq0", bus.imem_req_o, 0);
        tick();
        chk("full_noreq1", bus.imem_req_o, 0);
        chk("full_hold_pc", bus.ir_pc_o, 32'h0);
        bus.ir_ready_i = 1'b1;
        tick();
        chk("pop1_ir", bus.ir_o, 32'h2222_2222);
        chk("pop1_irpc", bus.ir_pc_o, 32'h4);
        chk("pop1_noreq", bus.imem_req_o, 0);
        tick();
        bus.ir_ready_i = 1'b0;
        chk("pop2_valid", bus.ir_valid_o, 0);
        chk("resume_req", bus.imem_req_o, 1);
        chk("resume_addr", bus.imem_addr_o, 32'h8);
        // complete 0x8 so there is a queued entry to flush, then redirect during 0xC
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h3333_3333;
        tick();
        bus.imem_ack_i = 1'b0; pc_i = 32'hC;
        #1 chk("q8_valid", bus.ir_valid_o, 1);
        tick();
        chk("rd_addr", bus.imem_addr_o, 32'hC);
        redirect_i = 1'b1;
        #1 chk("rd_adv", pc_advance_o, 0);
        tick();
        redirect_i = 1'b0; pc_i = 32'h100;
        #1;
        chk("drop_flush", bus.ir_valid_o, 0);
        chk("drop_req", bus.imem_req_o, 1);
        chk("drop_addr", bus.imem_addr_o, 32'hC);
        tick();
        chk("drop_req2", bus.imem_req_o, 1);
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
        #1 chk("drop_ack_adv", pc_advance_o, 0);
        tick();
        bus.imem_ack_i = 1'b0;
        #1;
        chk("drop_done_req", bus.imem_req_o, 0);
        chk("drop_discard", bus.ir_valid_o, 0);
        tick();
        chk("new_req", bus.imem_req_o, 1);
        chk("new_addr", bus.imem_addr_o, 32'h100);
        // redirect coincident with ack
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h4444_4444; redirect_i = 1'b1;
        #1 chk("rdack_adv", pc_advance_o, 0);
        tick();
        bus.imem_ack_i = 1'b0; redirect_i = 1'b0; pc_i = 32'h200;
        #1;
        chk("rdack_valid", bus.ir_valid_o, 0);
        chk("rdack_req", bus.imem_req_o, 0);
        tick();
        chk("t200_addr", bus.imem_addr_o, 32'h200);
        // async reset mid-request with one queued entry
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h5555_5555;
        tick();
        bus.imem_ack_i = 1'b0; pc_i = 32'h204;
        #1 chk("pre_rst_ir", bus.ir_o, 32'h5555_5555);
        tick();
        chk("pre_rst_req", bus.imem_req_o, 1);
        #1 RESET = 1'b0;
        #1;
        chk("arst_req", bus.imem_req_o, 0);
        chk("arst_valid", bus.ir_valid_o, 0);
        chk("arst_ir", bus.ir_o, 0);
        tick();
        RESET = 1'b1;
        tick();
        chk("restart_req", bus.imem_req_o, 1);
        chk("restart_addr", bus.imem_addr_o, 32'h204);
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h6666_6666;
        tick();
        bus.imem_ack_i = 1'b0;
        #1 chk("restart_irpc", bus.ir_pc_o, 32'h204);
        // top-of-memory PC and unaligned PC
        pc_i = 32'hFFFF_FFFC; bus.ir_ready_i = 1'b1;
        tick();
        bus.ir_ready_i = 1'b0;
        chk("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        chk("wrap_popped", bus.ir_valid_o, 0);
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h7777_7777;
        #1 chk("wrap_adv", pc_advance_o, 1);
        tick();
        bus.imem_ack_i = 1'b0; pc_i = 32'h3;
        #1;
        chk("wrap_irpc", bus.ir_pc_o, 32'hFFFF_FFFC);
        chk("wrap_ir", bus.ir_o, 32'h7777_7777);
        tick();
        chk("unalign_req", bus.imem_req_o, 1);
        chk("unalign_addr", bus.imem_addr_o, 32'h0);
        bus.imem_ack_i = 1'b1;
        tick();
        bus.imem_ack_i = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
